// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame states, prefix bytes
// and the keyboard protocol responses that are not key events.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_REL   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  function automatic logic is_resp(input logic [7:0] b);
    case (b)
      8'hFA, 8'hAA, 8'hEE, 8'hFE,
      8'hFC, 8'h00, 8'hFF: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// PS/2 pin pair in, ps2_key event word and pulses out.
// master: pins/consumer side; slave: the receiver.
interface ps2_key_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        key_stb;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  ps2_key, key_stb, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_key, key_stb, frame_err
  );
endinterface

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF sync of clk/data, clk glitch filter,
// fall_o strobe on filtered clk 1->0, data_o = synced data.
module ps2_line_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    cs_q;
  logic [1:0]    ds_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;
  logic          flip;

  // cnt_q counts consecutive samples that differ from filt_q;
  // the FILT_LEN-th such sample flips the filtered level.
  assign flip = (cs_q[1] != filt_q) &&
                (cnt_q == CW'(FILT_LEN - 1));

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      cs_q   <= 2'b11;
      ds_q   <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      cs_q <= {cs_q[0], ps2_clk_i};
      ds_q <= {ds_q[0], ps2_data_i};
      if (cs_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        filt_q <= cs_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign fall_o = flip & filt_q;
  assign data_o = ds_q[1];

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frame FSM, parity/timeout checks,
// E0/F0/E1 prefix folding and response filtering into ps2_key.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN  = 8,
  parameter int TO_CYCLES = 100000,
  parameter int TO_W      = 17
) (
  input logic         clk_sys,
  input logic         RESET,
  ps2_key_rx_if.slave bus
);

  logic stb;
  logic din;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk_sys    (clk_sys),
    .RESET      (RESET),
    .ps2_clk_i  (bus.ps2_clk),
    .ps2_data_i (bus.ps2_data),
    .fall_o     (stb),
    .data_o     (din)
  );

  ps2_state_e  state_q, state_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic [TO_W-1:0] to_q, to_d;
  logic        ext_q, ext_d;
  logic        rel_q, rel_d;
  logic [2:0]  skip_q, skip_d;
  logic [10:0] key_q, key_d;
  logic        kstb_q, kstb_d;
  logic        err_q, err_d;
  logic        accept;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    skip_d  = skip_q;
    key_d   = key_q;
    kstb_d  = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;

    if (stb || state_q == IDLE) to_d = '0;
    else                        to_d = to_q + 1'b1;

    unique case (state_q)
      IDLE: if (stb) begin
        if (!din) begin
          state_d = SHIFT;
          bcnt_d  = 3'd0;
        end else begin
          err_d = 1'b1;
        end
      end
      SHIFT: if (stb) begin
        sh_d   = {din, sh_q[7:1]};
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (stb) begin
        par_d   = ^{sh_q, din};
        state_d = STOP;
      end
      STOP: if (stb) begin
        state_d = IDLE;
        if (din && par_q) accept = 1'b1;
        else              err_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !stb &&
        to_q == TO_W'(TO_CYCLES - 1)) begin
      state_d = IDLE;
      to_d    = '0;
      err_d   = 1'b1;
    end

    // Decode straight off the stop strobe so key_stb lands
    // one cycle after it.
    if (accept) begin
      priority case (1'b1)
        skip_q != 3'd0: skip_d = skip_q - 3'd1;
        sh_q == PS2_EXT: ext_d = 1'b1;
        sh_q == PS2_REL: rel_d = 1'b1;
        sh_q == PS2_PAUSE: skip_d = 3'd7;
        is_resp(sh_q): begin
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
        default: begin
          key_d  = {~key_q[10], ~rel_q, ext_q, sh_q};
          kstb_d = 1'b1;
          ext_d  = 1'b0;
          rel_d  = 1'b0;
        end
      endcase
    end

    if (err_d) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      skip_q  <= '0;
      key_q   <= '0;
      kstb_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      to_q    <= to_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      skip_q  <= skip_d;
      key_q   <= key_d;
      kstb_q  <= kstb_d;
      err_q   <= err_d;
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.key_stb   = kstb_q;
  assign bus.frame_err = err_q;

endmodule
